// File: rtl/univ_reg_ctr.sv
// Universal shift register / up-down counter with per-bit preset and cen-qualified actions.
// Optional `USE_CEN_EDGE_EN: actions fire once per cen rising edge instead of every clk with cen high.
module univ_reg_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         rst_n,
  input  logic         cen,
  input  logic [2:0]   mode,
  input  logic [W-1:0] din,
  input  logic         sri,
  input  logic         sli,
  input  logic [W-1:0] setn,
  output logic [W-1:0] q,
  output logic [W-1:0] qn,
  output logic         tc,
  output logic         rco
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_UP   = 3'b100,
    MODE_DOWN = 3'b101,
    MODE_RSV6 = 3'b110,
    MODE_RSV7 = 3'b111
  } mode_e;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  mode_e        op;
  logic         en;
  logic [W-1:0] q_q, q_d, qn_q;
  logic [W-1:0] mode_res;

  assign op = mode_e'(mode);

`ifdef USE_CEN_EDGE_EN
  // last_cen resets high so a cen already asserted at reset release must drop before firing.
  logic last_cen_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_cen_q <= 1'b1;
    end else if (!rst_n) begin
      last_cen_q <= 1'b1;
    end else begin
      last_cen_q <= cen;
    end
  end

  assign en = cen & ~last_cen_q;
`else
  assign en = cen;
`endif

  always_comb begin
    mode_res = q_q;
    if (en) begin
      case (op)
        MODE_SHR:  mode_res = {sri, q_q[W-1:1]};
        MODE_SHL:  mode_res = {q_q[W-2:0], sli};
        MODE_LOAD: mode_res = din;
        MODE_UP:   mode_res = q_q + ONE;
        MODE_DOWN: mode_res = q_q - ONE;
        default:   mode_res = q_q;
      endcase
    end
    // Preset bits override the mode result bit by bit; untouched bits still advance.
    q_d = mode_res | ~setn;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_q  <= '0;
      qn_q <= '1;
    end else if (!rst_n) begin
      q_q  <= '0;
      qn_q <= '1;
    end else begin
      q_q  <= q_d;
      qn_q <= ~q_d;
    end
  end

  assign q   = q_q;
  assign qn  = qn_q;
  assign tc  = ((op == MODE_UP) && (&q_q)) || ((op == MODE_DOWN) && (~|q_q));
  assign rco = tc & en;

endmodule

// File: tb/tb_univ_reg_ctr.sv
// Scoreboard bench for univ_reg_ctr (W=4): directed vectors push expectations, a negedge monitor checks them.
module tb_univ_reg_ctr;

`ifdef USE_CEN_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn, rst_n, cen, sri, sli;
  logic [2:0] mode;
  logic [3:0] din, setn;
  logic [3:0] q, qn;
  logic       tc, rco;

  univ_reg_ctr #(.W(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .rst_n(rst_n),
    .cen  (cen),
    .mode (mode),
    .din  (din),
    .sri  (sri),
    .sli  (sli),
    .setn (setn),
    .q    (q),
    .qn   (qn),
    .tc   (tc),
    .rco  (rco)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] q;
    logic       tc;
    logic       rco;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: mid-cycle sample of registered state and combinational flags.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        if (q !== sb[i].q || qn !== ~sb[i].q || tc !== sb[i].tc || rco !== sb[i].rco) begin
          errors++;
          $display("FAIL %s: got q=%b qn=%b tc=%b rco=%b, expected q=%b qn=%b tc=%b rco=%b",
                   sb[i].name, q, qn, tc, rco, sb[i].q, ~sb[i].q, sb[i].tc, sb[i].rco);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: sample slot %0d missed at cycle %0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] eq, input logic etc, input logic erco);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.q    = eq;
    e.tc   = etc;
    e.rco  = erco;
    sb.push_back(e);
  endtask

  // Apply one cycle of inputs; expectation covers q from the edge just taken and tc/rco for these inputs.
  task automatic vec(input string nm, input logic c, input logic [2:0] m, input logic [3:0] d,
                     input logic sr, input logic sl, input logic [3:0] sn, input logic rn,
                     input logic [3:0] eq, input logic etc, input logic erco);
    @(posedge clk);
    #1;
    cen   = c;
    mode  = m;
    din   = d;
    sri   = sr;
    sli   = sl;
    setn  = sn;
    rst_n = rn;
    push(nm, eq, etc, erco);
  endtask

  initial begin
    clrn = 1'b0; rst_n = 1'b1; cen = 1'b0; mode = 3'b000;
    din = 4'b0000; sri = 1'b0; sli = 1'b0; setn = 4'b1111;
    repeat (2) @(posedge clk);

    //   name            cen mode    din      sri sli setn     rst  exp q                    tc           rco
    vec("reset",        0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b0000,              0,           0);
    clrn = 1'b1;
    vec("idle",         0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b0000,              0,           0);
    vec("load_a",       1, 3'b011, 4'b1010, 0, 0, 4'b1111, 1, 4'b0000,              0,           0);
    vec("q_1010",       0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b1010,              0,           0);

    @(posedge clk);
    #1;
    clrn = 1'b0;
    push("clrn_async", 4'b0000, 0, 0);
    @(negedge clk);
    #1;
    clrn = 1'b1;

    vec("post_clrn",    0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b0000,              0,           0);
    vec("load_e",       1, 3'b011, 4'b1110, 0, 0, 4'b1111, 1, 4'b0000,              0,           0);
    vec("cen_low",      0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b1110,              0,           0);
    vec("up_1",         1, 3'b100, 4'b0000, 0, 0, 4'b1111, 1, 4'b1110,              0,           0);
    vec("up_2",         1, 3'b100, 4'b0000, 0, 0, 4'b1111, 1, 4'b1111,              1,           !EDGE);
    vec("up_3",         1, 3'b100, 4'b0000, 0, 0, 4'b1111, 1, EDGE ? 4'b1111 : 4'b0000, EDGE,    0);
    vec("up_done",      0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, EDGE ? 4'b1111 : 4'b0001, 0,       0);
    vec("load_z",       1, 3'b011, 4'b0000, 0, 0, 4'b1111, 1, EDGE ? 4'b1111 : 4'b0001, 0,       0);
    vec("z",            0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b0000,              0,           0);
    vec("down",         1, 3'b101, 4'b0000, 0, 0, 4'b1111, 1, 4'b0000,              1,           1);
    vec("down_wrap",    0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b1111,              0,           0);
    vec("load_8",       1, 3'b011, 4'b1000, 0, 0, 4'b1111, 1, 4'b1111,              0,           0);
    vec("shr_prep",     0, 3'b001, 4'b0000, 1, 0, 4'b1111, 1, 4'b1000,              0,           0);
    vec("shr",          1, 3'b001, 4'b0000, 1, 0, 4'b1111, 1, 4'b1000,              0,           0);
    vec("shl_prep",     0, 3'b010, 4'b0000, 0, 0, 4'b1111, 1, 4'b1100,              0,           0);
    vec("shl",          1, 3'b010, 4'b0000, 1, 0, 4'b1111, 1, 4'b1100,              0,           0);
    vec("shl_res",      0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b1000,              0,           0);
    vec("load_set",     1, 3'b011, 4'b0101, 0, 0, 4'b1110, 1, 4'b1000,              0,           0);
    vec("load_set_res", 0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b0101,              0,           0);
    vec("set_noen",     0, 3'b011, 4'b0000, 0, 0, 4'b0111, 1, 4'b0101,              0,           0);
    vec("set_res",      0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b1101,              0,           0);
    vec("rst_hit",      1, 3'b100, 4'b0000, 0, 0, 4'b0000, 0, 4'b1101,              0,           0);
    vec("rst_res",      1, 3'b100, 4'b0000, 0, 0, 4'b1111, 1, 4'b0000,              0,           0);
    vec("cen_stuck",    1, 3'b100, 4'b0000, 0, 0, 4'b1111, 1, EDGE ? 4'b0000 : 4'b0001, 0,       0);
    vec("cen_low2",     0, 3'b100, 4'b0000, 0, 0, 4'b1111, 1, EDGE ? 4'b0000 : 4'b0010, 0,       0);
    vec("cen_rise",     1, 3'b100, 4'b0000, 0, 0, 4'b1111, 1, EDGE ? 4'b0000 : 4'b0010, 0,       0);
    vec("cen_fire",     0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, EDGE ? 4'b0001 : 4'b0011, 0,       0);
    vec("load_f",       1, 3'b011, 4'b1111, 0, 0, 4'b1111, 1, EDGE ? 4'b0001 : 4'b0011, 0,       0);
    vec("f",            0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b1111,              0,           0);
    vec("up_wrap",      1, 3'b100, 4'b0000, 0, 0, 4'b1111, 1, 4'b1111,              1,           1);
    vec("wrap_res",     0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b0000,              0,           0);
    vec("load_9",       1, 3'b011, 4'b1001, 0, 0, 4'b1111, 1, 4'b0000,              0,           0);
    vec("m110_prep",    0, 3'b110, 4'b0000, 0, 0, 4'b1111, 1, 4'b1001,              0,           0);
    vec("m110",         1, 3'b110, 4'b0110, 1, 1, 4'b1111, 1, 4'b1001,              0,           0);
    vec("m110_res",     0, 3'b000, 4'b0000, 0, 0, 4'b1111, 1, 4'b1001,              0,           0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation never sampled (slot %0d)", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
